seg7_scan_display: RTL and testbench

//  Drives the 4-digit multiplexed 7-segment display, downstream of the event counter FSM.

---
 rtl/seg7_scan_display_if.sv | 24 ++
 rtl/seg7_scan_display.sv | 92 +++++++++
 tb/tb_seg7_scan_display.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_display_if.sv
// Bus between the digit source and the 4-digit 7-segment scan driver.
// Groups the capture strobe, digit/dp inputs and the board-side segment/enable outputs.
interface seg7_scan_display_if;
  // load_i is a strobe with no ready: every clk edge that sees load_i=1 captures
  // digit0_i..digit3_i and dp_i, and the driver always accepts (no back-pressure).
  logic       load_i;
  logic [3:0] digit0_i;
  logic [3:0] digit1_i;
  logic [3:0] digit2_i;
  logic [3:0] digit3_i;
  logic [3:0] dp_i;
  logic [7:0] ledcx_o;
  logic [3:0] leden_o;

  modport master (
    output load_i, digit0_i, digit1_i, digit2_i, digit3_i, dp_i,
    input  ledcx_o, leden_o
  );

  modport slave (
    input  load_i, digit0_i, digit1_i, digit2_i, digit3_i, dp_i,
    output ledcx_o, leden_o
  );
endinterface

// File: rtl/seg7_scan_display.sv
// 4-digit multiplexed 7-segment driver: shadow-captures digits on load, scans one digit per slot.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1 (dp still shown).
module seg7_scan_display #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1_000
) (
  input logic           clk_i,
  input logic           rst_i,
  seg7_scan_display_if.slave bus
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  logic [PW-1:0]      presc;
  logic               tick;
  logic [1:0]         idx;
  logic [3:0][3:0]    sdig;
  logic [3:0]         sdp;
  logic [3:0]         blank;
  logic [3:0]         cur_dig;
  logic [6:0]         cur_seg;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  assign tick = (presc == DIV_M1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      presc <= '0;
      idx   <= 2'd0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx + 2'd1;
    end
  end

  // Load is independent of the scan timing; each strobed edge overwrites the shadow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sdig <= '0;
      sdp  <= '0;
    end else if (bus.load_i) begin
      sdig <= {bus.digit3_i, bus.digit2_i, bus.digit1_i, bus.digit0_i};
      sdp  <= bus.dp_i;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign blank[3] = (sdig[3] == 4'h0);
  assign blank[2] = (sdig[3] == 4'h0) && (sdig[2] == 4'h0);
  assign blank[1] = (sdig[3] == 4'h0) && (sdig[2] == 4'h0) && (sdig[1] == 4'h0);
  assign blank[0] = 1'b0;
`else
  assign blank = 4'b0000;
`endif

  assign cur_dig = sdig[idx];
  assign cur_seg = blank[idx] ? 7'h00 : seg7(cur_dig);

  // Enables and segments share one register stage so they switch together (no ghosting).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.ledcx_o <= 8'h00;
      bus.leden_o <= 4'b0000;
    end else begin
      bus.ledcx_o <= {sdp[idx], cur_seg};
      bus.leden_o <= 4'b0001 << idx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with DIV=4: table-driven load/scan vectors
// plus hand-written reset, hold and load-timing sequences.
module tb_seg7_scan_display;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct {
    logic [15:0]     digs;  // {d3,d2,d1,d0}
    logic [3:0]      dp;
    logic [3:0][7:0] exp;   // exp[n] = ledcx_o while digit n is enabled
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  vec_t vecs [7];

  seg7_scan_display_if bus ();

  seg7_scan_display #(.CLK_HZ(8), .SCAN_HZ(2)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] zero_frame_seg(input int slot);
    return (slot == 0 || !BLANK) ? 8'h3F : 8'h00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_inputs(input logic [15:0] d, input logic [3:0] dp, input logic ld);
    bus.digit0_i = d[3:0];
    bus.digit1_i = d[7:4];
    bus.digit2_i = d[11:8];
    bus.digit3_i = d[15:12];
    bus.dp_i     = dp;
    bus.load_i   = ld;
  endtask

  task automatic apply_load(input logic [15:0] d, input logic [3:0] dp);
    @(negedge clk);
    drive_inputs(d, dp, 1'b1);
    @(posedge clk);
    #1 bus.load_i = 1'b0;
    @(posedge clk);
  endtask

  task automatic check_frame(input string name, input logic [3:0][7:0] exp);
    int slot;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      case (bus.leden_o)
        4'b0001: slot = 0;
        4'b0010: slot = 1;
        4'b0100: slot = 2;
        4'b1000: slot = 3;
        default: slot = -1;
      endcase
      if (slot < 0) chk({name, "_onehot"}, {28'd0, bus.leden_o}, 32'h1);
      else          chk({name, "_seg"}, {24'd0, bus.ledcx_o}, {24'd0, exp[slot]});
    end
  endtask

  // Checks the reset-release scan pattern for `cycles` edges with an all-zero shadow.
  task automatic check_restart(input string name, input int cycles);
    int slot;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      slot = ((k - 1) / 4) % 4;
      chk({name, "_en"},  {28'd0, bus.leden_o}, {28'd0, 4'b0001 << slot});
      chk({name, "_seg"}, {24'd0, bus.ledcx_o}, {24'd0, zero_frame_seg(slot)});
    end
  endtask

  // Bounded wait until leden_o has just switched to `target` (sampled at negedge).
  task automatic wait_slot_entry(input logic [3:0] target, input string name);
    logic [3:0] prev;
    bit         found;
    found = 1'b0;
    @(negedge clk);
    prev = bus.leden_o;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.leden_o == target && prev != target) found = 1'b1;
      prev = bus.leden_o;
    end
    if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive_inputs(16'h0000, 4'h0, 1'b0);

    vecs[0] = '{16'h1234, 4'b0000, {8'h06, 8'h5B, 8'h4F, 8'h66}};
    vecs[1] = '{16'hABCD, 4'b0101, {8'h77, 8'hFC, 8'h39, 8'hDE}};
    vecs[2] = '{16'h0070, 4'b0000,
                BLANK ? {8'h00, 8'h00, 8'h07, 8'h3F} : {8'h3F, 8'h3F, 8'h07, 8'h3F}};
    vecs[3] = '{16'h5678, 4'b1010, {8'hED, 8'h7D, 8'h87, 8'h7F}};
    vecs[4] = '{16'h9EF0, 4'b1000, {8'hEF, 8'h79, 8'h71, 8'h3F}};
    vecs[5] = '{16'h0005, 4'b0100,
                BLANK ? {8'h00, 8'h80, 8'h00, 8'h6D} : {8'h3F, 8'hBF, 8'h3F, 8'h6D}};
    vecs[6] = '{16'h0100, 4'b0000,
                BLANK ? {8'h00, 8'h06, 8'h3F, 8'h3F} : {8'h3F, 8'h06, 8'h3F, 8'h3F}};

    // Reset held: outputs at reset values
    repeat (3) @(negedge clk);
    chk("rst_seg", {24'd0, bus.ledcx_o}, 32'h00);
    chk("rst_en",  {28'd0, bus.leden_o}, 32'h0);
    rst_n = 1'b1;
    check_restart("scan", 20);

    // Table-driven load/scan vectors
    foreach (vecs[i]) begin
      apply_load(vecs[i].digs, vecs[i].dp);
      check_frame($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Inputs change without load: shadow holds
    @(negedge clk);
    drive_inputs(16'h8888, 4'hF, 1'b0);
    check_frame("hold", vecs[6].exp);

    // Load at the start of slot 0: new value one edge after the load edge
    wait_slot_entry(4'b0001, "slot0");
    drive_inputs(16'h1234, 4'h0, 1'b1);
    @(posedge clk);
    #1 bus.load_i = 1'b0;
    @(negedge clk);
    chk("ld_edge_seg", {24'd0, bus.ledcx_o}, {24'd0, vecs[6].exp[0]});
    chk("ld_edge_en",  {28'd0, bus.leden_o}, 32'h1);
    @(negedge clk);
    chk("ld_next_seg", {24'd0, bus.ledcx_o}, 32'h66);
    chk("ld_next_en",  {28'd0, bus.leden_o}, 32'h1);

    // Async reset mid slot 2
    wait_slot_entry(4'b0100, "slot2");
    @(negedge clk);
    chk("pre_rst_seg", {24'd0, bus.ledcx_o}, 32'h5B);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", {24'd0, bus.ledcx_o}, 32'h00);
    chk("async_rst_en",  {28'd0, bus.leden_o}, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_hold_seg", {24'd0, bus.ledcx_o}, 32'h00);
    rst_n = 1'b1;
    check_restart("restart", 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
